// File: rtl/audio_in_deserializer_pkg.sv
// Shared types and constants for the audio input path.
// Sample width matches the audio output side.
`timescale 1ns/1ps
package audio_in_deserializer_pkg;

    localparam int AUDIO_OUT_WIDTH = 32;

    typedef enum logic [1:0] {
        WAIT_FRAME,
        SKIP,
        SHIFT,
        HOLD
    } rx_state_t;

endpackage

// File: rtl/audio_pair_fifo.sv
// Show-ahead synchronous FIFO with a registered head word.
// Reusable for left/right sample pairs on either audio path.
`timescale 1ns/1ps
module audio_pair_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_ptr_nxt;
    logic [CW-1:0]    count_nxt;
    logic [WIDTH-1:0] head_nxt;
    logic             push;
    logic             pop;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign pop   = rd_en & ~empty;
    assign push  = wr_en & (~full | pop);

    always_comb begin
        rd_ptr_nxt = pop ? rd_ptr + AW'(1) : rd_ptr;
        count_nxt  = count + CW'(push) - CW'(pop);
        head_nxt   = '0;
        // A write landing on the new head slot bypasses the array
        if (count_nxt != '0) begin
            if (push && rd_ptr_nxt == wr_ptr)
                head_nxt = wr_data;
            else
                head_nxt = mem[rd_ptr_nxt];
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rd_data <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            rd_ptr  <= rd_ptr_nxt;
            count   <= count_nxt;
            rd_data <= head_nxt;
        end
    end

endmodule

// File: rtl/audio_in_deserializer.sv
// I2S ADC receiver: deserializes left/right words into 32-bit pairs
// and buffers them in a show-ahead FIFO for CLOCK_50 consumers.
`timescale 1ns/1ps
module audio_in_deserializer
    import audio_in_deserializer_pkg::*;
#(
    parameter int DATA_WIDTH = 24,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          CLOCK_50,
    input  logic                          reset,
    input  logic                          AUD_BCLK,
    input  logic                          AUD_ADCLRCK,
    input  logic                          AUD_ADCDAT,
    input  logic                          read_audio_in,
    output logic                          audio_in_available,
    output logic [AUDIO_OUT_WIDTH-1:0]    left_channel_audio_in,
    output logic [AUDIO_OUT_WIDTH-1:0]    right_channel_audio_in,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam int PW    = 2 * AUDIO_OUT_WIDTH;

    logic bclk_meta, bclk_sync, bclk_hist;
    logic lrck_meta, lrck_sync, lrck_hist;
    logic adc_meta, adc_sync;
    logic bclk_rise, lrck_edge, lrck_fall;

    rx_state_t state, state_nxt;

    logic [DATA_WIDTH-1:0]      shift_reg;
    logic [DATA_WIDTH-1:0]      shift_nxt;
    logic [CNT_W-1:0]           bit_cnt;
    logic                       last_bit;
    logic [AUDIO_OUT_WIDTH-1:0] word_just;
    logic [AUDIO_OUT_WIDTH-1:0] left_hold;
    logic [AUDIO_OUT_WIDTH-1:0] right_word;
    logic                       ch_right;
    logic                       left_valid;
    logic                       pair_wr;

    logic enter_skip;
    logic shift_en;
    logic word_done;

    logic [PW-1:0] pair_head;
    logic          fifo_full;
    logic          fifo_empty;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            bclk_meta <= 1'b0;
            bclk_sync <= 1'b0;
            bclk_hist <= 1'b0;
            lrck_meta <= 1'b0;
            lrck_sync <= 1'b0;
            lrck_hist <= 1'b0;
            adc_meta  <= 1'b0;
            adc_sync  <= 1'b0;
        end else begin
            bclk_meta <= AUD_BCLK;
            bclk_sync <= bclk_meta;
            bclk_hist <= bclk_sync;
            lrck_meta <= AUD_ADCLRCK;
            lrck_sync <= lrck_meta;
            lrck_hist <= lrck_sync;
            adc_meta  <= AUD_ADCDAT;
            adc_sync  <= adc_meta;
        end
    end

    assign bclk_rise = bclk_sync & ~bclk_hist;
    assign lrck_edge = lrck_sync ^ lrck_hist;
    assign lrck_fall = lrck_edge & ~lrck_sync;
    assign last_bit  = (bit_cnt == CNT_W'(DATA_WIDTH - 1));
    assign shift_nxt = (shift_reg << 1) | DATA_WIDTH'(adc_sync);
    assign word_just = AUDIO_OUT_WIDTH'(shift_nxt)
                       << (AUDIO_OUT_WIDTH - DATA_WIDTH);

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset)
            state <= WAIT_FRAME;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            WAIT_FRAME: if (lrck_fall) state_nxt = SKIP;
            SKIP: begin
                if (!lrck_edge && bclk_rise)
                    state_nxt = SHIFT;
            end
            SHIFT: begin
                if (lrck_edge)
                    state_nxt = SKIP;
                else if (bclk_rise && last_bit)
                    state_nxt = HOLD;
            end
            HOLD: if (lrck_edge) state_nxt = SKIP;
            default: state_nxt = WAIT_FRAME;
        endcase
    end

    always_comb begin
        enter_skip = 1'b0;
        shift_en   = 1'b0;
        word_done  = 1'b0;
        unique case (state)
            WAIT_FRAME: enter_skip = lrck_fall;
            SKIP:       enter_skip = lrck_edge;
            SHIFT: begin
                enter_skip = lrck_edge;
                shift_en   = bclk_rise & ~lrck_edge;
                word_done  = bclk_rise & ~lrck_edge & last_bit;
            end
            HOLD:       enter_skip = lrck_edge;
            default: ;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            shift_reg  <= '0;
            bit_cnt    <= '0;
            ch_right   <= 1'b0;
            left_valid <= 1'b0;
            left_hold  <= '0;
            right_word <= '0;
            pair_wr    <= 1'b0;
        end else begin
            pair_wr <= word_done & ch_right & left_valid;
            // A new left frame always opens a fresh pair
            if (enter_skip) begin
                ch_right <= lrck_sync;
                bit_cnt  <= '0;
                if (!lrck_sync)
                    left_valid <= 1'b0;
            end
            if (shift_en) begin
                shift_reg <= shift_nxt;
                bit_cnt   <= bit_cnt + CNT_W'(1);
            end
            if (word_done && !ch_right) begin
                left_hold  <= word_just;
                left_valid <= 1'b1;
            end
            if (word_done && ch_right) begin
                right_word <= word_just;
                left_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset)
            overflow <= 1'b0;
        else if (pair_wr && fifo_full && !(read_audio_in && !fifo_empty))
            overflow <= 1'b1;
    end

    audio_pair_fifo #(
        .WIDTH (PW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (CLOCK_50),
        .rst     (reset),
        .wr_en   (pair_wr),
        .wr_data ({left_hold, right_word}),
        .rd_en   (read_audio_in),
        .rd_data (pair_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign audio_in_available     = ~fifo_empty;
    assign left_channel_audio_in  = pair_head[PW-1:AUDIO_OUT_WIDTH];
    assign right_channel_audio_in = pair_head[AUDIO_OUT_WIDTH-1:0];

endmodule

// File: tb/tb_audio_in_deserializer.sv
// Directed bench for audio_in_deserializer: I2S frames driven at
// BCLK = CLOCK_50/16 with edges aligned to CLOCK_50 falling edges.
`timescale 1ns/1ps
module tb_audio_in_deserializer;

    logic        clk;
    logic        rst;
    logic        bclk;
    logic        lrck;
    logic        dat;
    logic        rd;
    logic        avail;
    logic [31:0] left;
    logic [31:0] right;
    logic [3:0]  count;
    logic        ovf;

    int checks;
    int errors;

    typedef struct {
        logic [23:0] l;
        logic [23:0] r;
        logic [31:0] exp_l;
        logic [31:0] exp_r;
    } vec_t;

    vec_t vecs[4];

    audio_in_deserializer #(
        .DATA_WIDTH (24),
        .FIFO_DEPTH (8)
    ) dut (
        .CLOCK_50               (clk),
        .reset                  (rst),
        .AUD_BCLK               (bclk),
        .AUD_ADCLRCK            (lrck),
        .AUD_ADCDAT             (dat),
        .read_audio_in          (rd),
        .audio_in_available     (avail),
        .left_channel_audio_in  (left),
        .right_channel_audio_in (right),
        .fifo_count             (count),
        .overflow               (ovf)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_avail"}, 64'(avail), 64'd0);
        check({tag, "_left"}, 64'(left), 64'd0);
        check({tag, "_right"}, 64'(right), 64'd0);
        check({tag, "_count"}, 64'(count), 64'd0);
        check({tag, "_ovf"}, 64'(ovf), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // mode 1: pulse read on the write cycle; mode 2: check write latency
    task automatic send_channel(input logic lr, input logic [23:0] w,
                                input int nbits, input int mode);
        for (int i = 0; i < nbits; i++) begin
            logic d;
            d = 1'b0;
            if (i >= 1 && i <= 24)
                d = w[24-i];
            @(negedge clk);
            bclk = 1'b0;
            lrck = lr;
            dat  = d;
            repeat (7) @(negedge clk);
            @(negedge clk);
            bclk = 1'b1;
            if (mode != 0 && i == 24) begin
                repeat (3) @(negedge clk);
                if (mode == 1)
                    rd = 1'b1;
                if (mode == 2)
                    check("lat_pre_avail", 64'(avail), 64'd0);
                @(negedge clk);
                if (mode == 1)
                    rd = 1'b0;
                if (mode == 2) begin
                    check("lat_post_avail", 64'(avail), 64'd1);
                    check("lat_post_count", 64'(count), 64'd1);
                end
                repeat (3) @(negedge clk);
            end else begin
                repeat (7) @(negedge clk);
            end
        end
    endtask

    task automatic send_pair(input logic [23:0] l, input logic [23:0] r,
                             input int mode);
        send_channel(1'b0, l, 32, 0);
        send_channel(1'b1, r, 32, mode);
    endtask

    task automatic pop();
        @(negedge clk);
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
    endtask

    task automatic check_head(input string tag, input logic [31:0] el,
                              input logic [31:0] er);
        check({tag, "_l"}, 64'(left), 64'(el));
        check({tag, "_r"}, 64'(right), 64'(er));
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        logic [23:0] pl;
        logic [23:0] pr;
        checks = 0;
        errors = 0;
        rst  = 1'b1;
        bclk = 1'b1;
        lrck = 1'b1;
        dat  = 1'b0;
        rd   = 1'b0;

        vecs[0] = '{24'h123456, 24'hABCDEF, 32'h12345600, 32'hABCDEF00};
        vecs[1] = '{24'h800000, 24'h7FFFFF, 32'h80000000, 32'h7FFFFF00};
        vecs[2] = '{24'h000000, 24'hFFFFFF, 32'h00000000, 32'hFFFFFF00};
        vecs[3] = '{24'hA5A5A5, 24'h5A5A5A, 32'hA5A5A500, 32'h5A5A5A00};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_state("reset");

        for (int v = 0; v < 4; v++) begin
            send_pair(vecs[v].l, vecs[v].r, 2);
            check_head("vec", vecs[v].exp_l, vecs[v].exp_r);
            pop();
            check("vec_empty_after_pop", 64'(avail), 64'd0);
        end

        do_reset();
        send_channel(1'b1, 24'h777777, 20, 0);
        send_pair(24'h000001, 24'hFFFFFF, 2);
        check_head("midright", 32'h00000100, 32'hFFFFFF00);
        pop();

        send_channel(1'b0, 24'h3C3C3C, 11, 0);
        send_channel(1'b1, 24'h555555, 32, 0);
        check("short_left_count", 64'(count), 64'd0);
        send_channel(1'b0, 24'h666666, 32, 0);
        send_channel(1'b1, 24'h999999, 11, 0);
        check("short_right_count", 64'(count), 64'd0);
        send_pair(24'hC0FFEE, 24'h0BEEF0, 0);
        check("short_next_count", 64'(count), 64'd1);
        check_head("short_next", 32'hC0FFEE00, 32'h0BEEF000);
        pop();

        do_reset();
        for (int i = 1; i <= 9; i++) begin
            pl = 24'h100000 + 24'(i);
            pr = 24'h200000 + 24'(i);
            send_pair(pl, pr, 0);
        end
        check("ovf_count", 64'(count), 64'd8);
        check("ovf_flag", 64'(ovf), 64'd1);
        for (int i = 1; i <= 8; i++) begin
            check_head("ovf_pop", {24'h100000 + 24'(i), 8'h00},
                       {24'h200000 + 24'(i), 8'h00});
            pop();
        end
        check("ovf_drained", 64'(avail), 64'd0);

        do_reset();
        for (int i = 1; i <= 8; i++) begin
            pl = 24'h300000 + 24'(i);
            pr = 24'h400000 + 24'(i);
            send_pair(pl, pr, 0);
        end
        check("fullrd_pre_count", 64'(count), 64'd8);
        send_pair(24'h300009, 24'h400009, 1);
        check("fullrd_count", 64'(count), 64'd8);
        check("fullrd_ovf", 64'(ovf), 64'd0);
        for (int i = 2; i <= 9; i++) begin
            check_head("fullrd_pop", {24'h300000 + 24'(i), 8'h00},
                       {24'h400000 + 24'(i), 8'h00});
            pop();
        end
        check("fullrd_drained", 64'(avail), 64'd0);

        do_reset();
        for (int i = 1; i <= 3; i++) begin
            pl = 24'h500000 + 24'(i);
            pr = 24'h600000 + 24'(i);
            send_pair(pl, pr, 0);
        end
        check("midshift_pre_count", 64'(count), 64'd3);
        send_channel(1'b0, 24'h111111, 12, 0);
        do_reset();
        check_reset_state("midshift");
        send_channel(1'b1, 24'h000000, 32, 0);
        send_pair(24'h0F0F0F, 24'hF0F0F0, 2);
        check_head("midshift_next", 32'h0F0F0F00, 32'hF0F0F000);
        pop();
        check("midshift_drained", 64'(avail), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
